// File: rtl/fetch_queue.sv
// Two-wide fetch-to-decode instruction queue: circular buffer with show-ahead outputs.
// Accepts up to two instructions and releases up to two per cycle, in program order.
module fetch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Flush,
    input  logic                       InValidA,
    input  logic                       InValidB,
    input  logic [31:0]                PCPlus4InA,
    input  logic [31:0]                PCPlus4InB,
    input  logic [31:0]                InstrInA,
    input  logic [31:0]                InstrInB,
    output logic                       InReady,
    input  logic                       DeqA,
    input  logic                       DeqB,
    output logic                       OutValidA,
    output logic                       OutValidB,
    output logic [31:0]                PCPlus4OutA,
    output logic [31:0]                PCPlus4OutB,
    output logic [31:0]                InstrOutA,
    output logic [31:0]                InstrOutB,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] ReadyMax = CW'(DEPTH - 2);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_p1, tail_p1;

    logic          enq_a, enq_b, deq_a, deq_b;
    logic [1:0]    enq_cnt, deq_cnt;

    assign head_p1 = head_q + 1'b1;
    assign tail_p1 = tail_q + 1'b1;

    // Readiness uses only the registered count so InReady never depends on DeqA/DeqB.
    assign InReady   = (count_q <= ReadyMax);
    assign OutValidA = (count_q >= CW'(1));
    assign OutValidB = (count_q >= CW'(2));

    assign enq_a   = InReady & InValidA;
    assign enq_b   = enq_a & InValidB;
    assign deq_a   = DeqA & OutValidA;
    assign deq_b   = DeqA & DeqB & OutValidB;
    assign enq_cnt = {1'b0, enq_a} + {1'b0, enq_b};
    assign deq_cnt = {1'b0, deq_a} + {1'b0, deq_b};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (Flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(deq_cnt);
            tail_d  = tail_q + AW'(enq_cnt);
            count_d = count_q + CW'(enq_cnt) - CW'(deq_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never cleared; validity comes from the count alone.
    always_ff @(posedge clk) begin
        if (enq_a && !Flush) begin
            pc_mem_q[tail_q]    <= PCPlus4InA;
            instr_mem_q[tail_q] <= InstrInA;
        end
        if (enq_b && !Flush) begin
            pc_mem_q[tail_p1]    <= PCPlus4InB;
            instr_mem_q[tail_p1] <= InstrInB;
        end
    end

    assign PCPlus4OutA = OutValidA ? pc_mem_q[head_q]     : '0;
    assign InstrOutA   = OutValidA ? instr_mem_q[head_q]  : '0;
    assign PCPlus4OutB = OutValidB ? pc_mem_q[head_p1]    : '0;
    assign InstrOutB   = OutValidB ? instr_mem_q[head_p1] : '0;
    assign Count       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed corner cases followed by random traffic,
// compared against a queue-based model of the instruction stream.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, Flush;
    logic        InValidA, InValidB, DeqA, DeqB;
    logic [31:0] PCPlus4InA, PCPlus4InB, InstrInA, InstrInB;
    logic        InReady, OutValidA, OutValidB;
    logic [31:0] PCPlus4OutA, PCPlus4OutB, InstrOutA, InstrOutB;
    logic [3:0]  Count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .Flush      (Flush),
        .InValidA   (InValidA),
        .InValidB   (InValidB),
        .PCPlus4InA (PCPlus4InA),
        .PCPlus4InB (PCPlus4InB),
        .InstrInA   (InstrInA),
        .InstrInB   (InstrInB),
        .InReady    (InReady),
        .DeqA       (DeqA),
        .DeqB       (DeqB),
        .OutValidA  (OutValidA),
        .OutValidB  (OutValidB),
        .PCPlus4OutA(PCPlus4OutA),
        .PCPlus4OutB(PCPlus4OutB),
        .InstrOutA  (InstrOutA),
        .InstrOutB  (InstrOutB),
        .Count      (Count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int          sz;
        logic [63:0] exp_a, exp_b;
        sz    = mq.size();
        exp_a = (sz >= 1) ? mq[0] : 64'h0;
        exp_b = 64'h0;
        if (sz >= 2) exp_b = mq[1];
        check_eq({tag, ".count"},    64'(Count),     64'(sz));
        check_eq({tag, ".valid_a"},  64'(OutValidA), 64'(sz >= 1));
        check_eq({tag, ".valid_b"},  64'(OutValidB), 64'(sz >= 2));
        check_eq({tag, ".in_ready"}, 64'(InReady),   64'((DEPTH - sz) >= 2));
        check_eq({tag, ".lane_a"},   {PCPlus4OutA, InstrOutA}, exp_a);
        check_eq({tag, ".lane_b"},   {PCPlus4OutB, InstrOutB}, exp_b);
    endtask

    // Instruction-stream semantics: flush drops everything; otherwise retire, then accept.
    task automatic model_update();
        int sz, ndeq;
        bit ready;
        if (Flush) begin
            mq.delete();
        end else begin
            sz    = mq.size();
            ready = (DEPTH - sz) >= 2;
            ndeq  = 0;
            if (DeqA && sz >= 1) ndeq++;
            if (DeqA && DeqB && sz >= 2) ndeq++;
            repeat (ndeq) void'(mq.pop_front());
            if (ready && InValidA) begin
                mq.push_back({PCPlus4InA, InstrInA});
                if (InValidB) mq.push_back({PCPlus4InB, InstrInB});
            end
        end
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step(input string tag);
        check_outputs(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit va, input bit vb, input bit da, input bit db, input bit fl);
        InValidA   = va;
        InValidB   = vb;
        DeqA       = da;
        DeqB       = db;
        Flush      = fl;
        PCPlus4InA = $urandom;
        PCPlus4InB = $urandom;
        InstrInA   = $urandom;
        InstrInB   = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        check_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First pair lands at the head one cycle later.
        drive(1, 1, 0, 0, 0);
        PCPlus4InA = 32'h0040_0004; InstrInA = 32'h2008_0001;
        PCPlus4InB = 32'h0040_0008; InstrInB = 32'h2009_0002;
        step("first_pair_in");
        drive(0, 0, 0, 0, 0);
        check_eq("first_pair.a", {PCPlus4OutA, InstrOutA}, 64'h0040_0004_2008_0001);
        check_eq("first_pair.b", {PCPlus4OutB, InstrOutB}, 64'h0040_0008_2009_0002);
        check_eq("first_pair.count", 64'(Count), 64'd2);

        // Fill without dequeue: saturates at DEPTH, extra pairs dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0);
            step("fill");
        end
        check_eq("full.count", 64'(Count), 64'd8);
        check_eq("full.in_ready", 64'(InReady), 64'd0);

        // Single entry with a double dequeue removes only one.
        drive(0, 0, 0, 0, 1);
        step("flush_a");
        drive(1, 0, 0, 0, 0);
        step("one_in");
        drive(0, 0, 1, 1, 0);
        step("deq_two_of_one");
        check_eq("single_deq.count", 64'(Count), 64'd0);
        check_eq("single_deq.valid_a", 64'(OutValidA), 64'd0);
        check_eq("single_deq.data_a", {PCPlus4OutA, InstrOutA}, 64'h0);

        // Walk pointers toward the top, then exchange pairs across the wrap at Count=3.
        drive(1, 1, 0, 0, 0); step("wrap_prep0");
        drive(1, 1, 1, 1, 0); step("wrap_prep1");
        drive(1, 0, 0, 0, 0); step("wrap_prep2");
        check_eq("wrap.count_before", 64'(Count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 0);
            step("wrap_xchg");
        end
        check_eq("wrap.count_after", 64'(Count), 64'd3);

        // Flush beats concurrent enqueue and dequeue.
        drive(1, 1, 0, 0, 0); step("to_five");
        check_eq("flush.count_before", 64'(Count), 64'd5);
        drive(1, 1, 1, 1, 1); step("flush_busy");
        drive(0, 0, 0, 0, 0);
        check_eq("flush.count", 64'(Count), 64'd0);
        check_eq("flush.in_ready", 64'(InReady), 64'd1);

        // Asynchronous reset mid-stream.
        drive(1, 1, 0, 0, 0); step("pre_rst0");
        drive(1, 1, 0, 0, 0); step("pre_rst1");
        check_eq("pre_rst.count", 64'(Count), 64'd4);
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        mq.delete();
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 1, 0, 0, 0);
        step("post_rst_pair");
        drive(0, 0, 0, 0, 0);
        check_eq("post_rst.count", 64'(Count), 64'd2);
        step("post_rst_hold");

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom % 2,
                  ($urandom % 32) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries; power of two, minimum 4.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all control state.
REQ-004 Port: Flush  input  1  synchronous queue clear (branch/exception redirect).
REQ-005 Port: InValidA, InValidB  input  1 each  fetch lane A/B presents an instruction; B valid only with A.
REQ-006 Port: PCPlus4InA, PCPlus4InB  input  32 each  PC+4 of the incoming instruction, lanes A/B.
REQ-007 Port: InstrInA, InstrInB  input  32 each  incoming instruction word, lanes A/B.
REQ-008 Port: InReady  output  1  queue can accept two instructions this cycle.
REQ-009 Port: DeqA, DeqB  input  1 each  decode consumes the lane A/B output this cycle; DeqB only with DeqA.
REQ-010 Port: OutValidA, OutValidB  output  1 each  head entry / head+1 entry holds a valid instruction.
REQ-011 Port: PCPlus4OutA, PCPlus4OutB, InstrOutA, InstrOutB  output  32 each  head / head+1 contents, feeding the decode pipeline register.
REQ-012 Port: Count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries, each holding {PCPlus4, Instr}, with head pointer, tail pointer and occupancy counter.
REQ-014 InReady SHALL be 1 iff DEPTH - Count >= 2, computed from registered Count only (no same-cycle dequeue credit).
REQ-015 Enqueue SHALL occur on a clk edge when InReady=1 and InValidA=1: lane A written at tail, lane B (if InValidB) at tail+1; tail advances by 1 or 2.
REQ-016 InValidB=1 with InValidA=0 SHALL be ignored (no write).
REQ-017 Output SHALL be show-ahead: OutValidA = (Count>=1), OutValidB = (Count>=2), lane A data from head and lane B data from head+1, combinationally and with zero added latency.
REQ-018 Data outputs SHALL be driven to 0 when the corresponding OutValid is 0.
REQ-019 Dequeue count SHALL be DeqA&OutValidA plus DeqA&DeqB&OutValidB; DeqB without DeqA and Deq on an invalid lane SHALL be ignored.
REQ-020 Head SHALL advance by the dequeue count; pointers wrap modulo DEPTH.
REQ-021 Simultaneous enqueue and dequeue SHALL update Count = Count + enq - deq in one cycle; no overflow or underflow is reachable.
REQ-022 An instruction enqueued at edge N SHALL be visible on the outputs after edge N (one-cycle minimum fetch-to-output latency); no bypass from inputs to outputs.
REQ-023 Program order SHALL be preserved: lane A precedes lane B, and earlier enqueues precede later ones.
REQ-024 Flush SHALL have priority over enqueue and dequeue in the same cycle: head, tail, Count go to 0 and same-cycle inputs are dropped.
REQ-025 Storage contents need no reset or flush clearing; validity is derived solely from Count.

Reset
REQ-026 While reset=1, head=0, tail=0, Count=0, asynchronously.
REQ-027 During and after reset, OutValidA=OutValidB=0, all data outputs=0, InReady=1.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; the first enqueue after release is written to entry 0.

Verification
REQ-029 After reset, enqueue {A: 0x00400004/0x20080001, B: 0x00400008/0x20090002} -> next cycle OutValidA=OutValidB=1 with those values, Count=2.
REQ-030 Enqueue pairs every cycle with no dequeue (DEPTH=8) -> InReady falls when Count=7 or 8; Count saturates at 8; further InValid is ignored.
REQ-031 Count=1, DeqA=DeqB=1 -> only one entry removed, Count=0, OutValidA=0, outputs 0.
REQ-032 Count=3, enqueue 2 and dequeue 2 in the same cycle -> Count=3, order preserved across the pointer wrap past entry 7.
REQ-033 Count=5, Flush=1 together with InValidA=1 and DeqA=1 -> Count=0 next cycle, InReady=1, no entries retained.
REQ-034 Reset pulsed mid-stream with Count=4 -> outputs invalid immediately (asynchronous); the first post-release pair appears at head with Count=2.
